seq_detect_param: RTL
=====================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 4-bit Moore detector.
//  - Pattern up to PAT_W bits, runtime-programmable pattern and length.
//  - Overlapping or non-overlapping match mode; valid-qualified input.
//  - Registered (Moore) match pulse. Optional saturating match counter.
//  - Sits on a serial bit stream between a deserialiser/bit source and control logic.
// PARAMETERS
//  PAT_W    4        max pattern length in bits (>=2)
//  PAT_INIT 4'b1101  reset pattern (PAT_W bits); bit [len-1] is the first bit in time
//  LEN_INIT 4        reset pattern length (1..PAT_W)
//  OVERLAP  1        1 = overlapping matches allowed; 0 = history cleared after a match
//  CNT_W    8        match counter width (used only with SEQ_DET_COUNT_EN)
// PORTS
//  clk        in   1                  clock; all logic on posedge
//  rst        in   1                  synchronous, active-high reset
//  din        in   1                  serial data bit
//  din_valid  in   1                  din is sampled only when high
//  cfg_we     in   1                  load cfg_pattern/cfg_len this cycle
//  cfg_pattern in  PAT_W              new pattern
//  cfg_len    in   $clog2(PAT_W+1)    new length
//  cnt_clr    in   1                  clear match counter
//  dout       out  1                  match pulse, registered
//  match_cnt  out  CNT_W              saturating count of matches
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Reset: hist=0, fill=0, pat=PAT_INIT, len=LEN_INIT, dout=0, match_cnt=0.
//  - hist[PAT_W-1:0]: shift register, newest bit in hist[0]; shifts on din_valid.
//  - fill: counter 0..PAT_W of valid bits since reset/cfg/match; saturates at PAT_W.
//  - FSM (derived from fill): FILLING (fill < len) / ARMED (fill >= len).
//  - Match on an accepted bit:
//      * condition: next-fill >= len and next-hist[len-1:0] == pat[len-1:0].
//      * dout = 1 in the cycle after that bit is accepted, for exactly one cycle.
//      * dout = 0 otherwise, including cycles with din_valid low (1-cycle latency).
//  - After a match:
//      * OVERLAP=1: hist and fill unchanged; the suffix may start the next match.
//      * OVERLAP=0: fill <- 0 (completing bit not reused); hist is don't-care.
//  - cfg_we (priority over din_valid; same-cycle din is dropped):
//      * pat <= cfg_pattern; hist, fill <= 0; dout <= 0.
//      * len <= cfg_len, clamped: 0 -> 1, >PAT_W -> PAT_W.
//  - len=1: every accepted bit equal to pat[0] matches; no FILLING wait.
//  - rst in any cycle overrides cfg_we, cnt_clr and din_valid.
// CONFIGURATION
//  - SEQ_DET_COUNT_EN defined:
//      * match_cnt += 1 on each cycle dout=1; saturates at 2^CNT_W-1.
//      * cnt_clr zeroes the count; if a match occurs in the same cycle, result = 1.
//  - Not defined: match_cnt tied to 0; cnt_clr ignored; no counter flops.
// STRUCTURE
//  - Package seq_det_pkg: PAT_W-derived len width function, default pattern/length
//    constants, clamp function for cfg_len, fsm state typedef {FILLING, ARMED}.
//  - One sub-module: seq_det_sat_cnt (CNT_W saturating counter, inc/clr),
//    instantiated under SEQ_DET_COUNT_EN.
// TESTING
//  1. Defaults, OVERLAP=1, din=1,1,0,1,1,0,1 (valid every cycle) -> dout pulses after
//     bits 4 and 7; match_cnt=2.
//  2. OVERLAP=0, same stream -> single pulse after bit 4; match_cnt=1.
//  3. Stream 1,1,0,1 with din_valid low between bits (gaps of 0..3 cycles) -> one pulse,
//     exactly 1 cycle after the 4th valid bit; no pulse during gaps.
//  4. cfg_we pattern=4'b0010, len=3 (pattern 010), stream 0,1,0,1,0 (overlap) -> pulses
//     after bits 3 and 5; cfg_len=0 loaded -> len=1; cfg_len=7 -> len=PAT_W.
//  5. rst asserted mid-pattern after 1,1,0 -> dout=0; next stream 1 gives no match;
//     pattern restored to 1101.
//  6. With SEQ_DET_COUNT_EN, CNT_W=2: 5 matches -> match_cnt=3 (saturated);
//     cnt_clr coincident with a match -> match_cnt=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DefPatW    = 4;
  localparam logic [3:0]  DefPattern = 4'b1101;
  localparam int unsigned DefLen     = 4;

  typedef enum logic {
    Filling,
    Armed
  } fsm_state_e;

  // Width needed to hold a length in 0..pat_w.
  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    if (len == 0) begin
      return 1;
    end
    if (len > pat_w) begin
      return pat_w;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with clear; a clear coincident with an increment yields 1.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W    = DefPatW,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DefPattern),
  parameter int unsigned      LEN_INIT = DefLen,
  parameter bit               OVERLAP  = 1'b1,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_we,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [len_width(PAT_W)-1:0]  cfg_len,
  input  logic                         cnt_clr,
  output logic                         dout,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int unsigned      LenW    = len_width(PAT_W);
  localparam logic [LenW-1:0]  FillMax = LenW'(PAT_W);
  localparam logic [LenW-1:0]  LenRst  = LenW'(clamp_len(LEN_INIT, PAT_W));

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LenW-1:0]  fill_q, fill_d;
  logic [LenW-1:0]  len_q, len_d;
  fsm_state_e       state_q, state_d;
  logic             dout_q, dout_d;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LenW-1:0]  fill_inc;
  logic             armed_next;
  logic             match;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign hist_shift = {hist_q[PAT_W-2:0], din};
  assign fill_inc   = (fill_q == FillMax) ? fill_q : fill_q + LenW'(1);
  // Once armed, fill never drops below len without a cfg/match/reset clearing it.
  assign armed_next = (state_q == Armed) || (fill_inc >= len_q);
  assign match      = din_valid && !cfg_we && armed_next &&
                      (((hist_shift ^ pat_q) & len_mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    dout_d = 1'b0;
    if (cfg_we) begin
      pat_d  = cfg_pattern;
      len_d  = LenW'(clamp_len(32'(cfg_len), PAT_W));
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      dout_d = match;
      if (match && !OVERLAP) begin
        fill_d = '0;
      end
    end
    state_d = (fill_d >= len_d) ? Armed : Filling;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_INIT;
      len_q   <= LenRst;
      state_q <= Filling;
      dout_q  <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef SEQ_DET_COUNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk(clk),
    .rst(rst),
    .inc(dout_q),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
